// File: rtl/tsi_link_arbiter.sv
`timescale 1ns/1ps
// tsi_link_arbiter
//   Shares one 32-bit TSI link (target side) between two host-side TSI
//   clients. Grants are round-robin and held for a whole request packet;
//   the request header is parsed to find where the packet ends. Read
//   responses are steered back to the client that issued the read. Data
//   words pass through combinationally; only header parsing and grant
//   state are registered.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   cN_req_valid/ready/bits      request stream from client N (N = 0, 1)
//   cN_resp_valid/ready/bits     response stream to client N
//   t_req_valid/ready/bits       request stream to the target
//   t_resp_valid/ready/bits      response stream from the target
//   busy                         a packet is in progress
//   owner                        index of the currently granted client
//   len_err                      sticky: a length word other than word 0 was nonzero
//
// Parameters
//   ADDR_WORDS   address words per request header (1..4)
//   LEN_WORDS    length words per request header (1..4); word 0 carries L
module tsi_link_arbiter #(
  parameter int ADDR_WORDS = 2,
  parameter int LEN_WORDS  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c0_req_valid,
  output logic        c0_req_ready,
  input  logic [31:0] c0_req_bits,
  output logic        c0_resp_valid,
  input  logic        c0_resp_ready,
  output logic [31:0] c0_resp_bits,
  input  logic        c1_req_valid,
  output logic        c1_req_ready,
  input  logic [31:0] c1_req_bits,
  output logic        c1_resp_valid,
  input  logic        c1_resp_ready,
  output logic [31:0] c1_resp_bits,
  output logic        t_req_valid,
  input  logic        t_req_ready,
  output logic [31:0] t_req_bits,
  input  logic        t_resp_valid,
  output logic        t_resp_ready,
  input  logic [31:0] t_resp_bits,
  output logic        busy,
  output logic        owner,
  output logic        len_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, LEN, WDATA, RDATA} state_t;

  localparam logic [1:0] ADDR_LAST = 2'(ADDR_WORDS - 1);
  localparam logic [1:0] LEN_LAST  = 2'(LEN_WORDS - 1);

  state_t      state;
  logic        last_grant;
  logic        is_write;
  logic [1:0]  beat;
  // 33 bits so that L = 0xFFFFFFFF gives 0x1_0000_0000 words without wrapping
  logic [32:0] remaining;

  logic        req_phase;
  logic        rd_phase;
  logic        sel_req_valid;
  logic [31:0] sel_req_bits;
  logic        sel_resp_ready;
  logic        req_fire;
  logic        resp_fire;
  logic        grant;

  assign req_phase = (state == CMD) || (state == ADDR) ||
                     (state == LEN) || (state == WDATA);
  assign rd_phase  = (state == RDATA);

  assign sel_req_valid  = owner ? c1_req_valid  : c0_req_valid;
  assign sel_req_bits   = owner ? c1_req_bits   : c0_req_bits;
  assign sel_resp_ready = owner ? c1_resp_ready : c0_resp_ready;

  // Request path: owner's stream is forwarded only while a header/data
  // phase is active; everything is forced to zero otherwise.
  assign t_req_valid  = req_phase && sel_req_valid;
  assign t_req_bits   = req_phase ? sel_req_bits : 32'd0;
  assign c0_req_ready = req_phase && !owner && t_req_ready;
  assign c1_req_ready = req_phase &&  owner && t_req_ready;

  // Response path: open only during RDATA, so stray target words stall.
  assign t_resp_ready  = rd_phase && sel_resp_ready;
  assign c0_resp_valid = rd_phase && !owner && t_resp_valid;
  assign c1_resp_valid = rd_phase &&  owner && t_resp_valid;
  assign c0_resp_bits  = (rd_phase && !owner) ? t_resp_bits : 32'd0;
  assign c1_resp_bits  = (rd_phase &&  owner) ? t_resp_bits : 32'd0;

  assign req_fire  = t_req_valid && t_req_ready;
  assign resp_fire = t_resp_valid && t_resp_ready;

  // On a tie the client that did not win last time goes next.
  assign grant = (c0_req_valid && c1_req_valid) ? ~last_grant : c1_req_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      len_err    <= 1'b0;
      beat       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (c0_req_valid || c1_req_valid) begin
            owner      <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            beat       <= 2'd0;
            state      <= CMD;
          end
        end
        CMD: begin
          if (req_fire) begin
            beat  <= 2'd0;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (req_fire) begin
            if (beat == ADDR_LAST) begin
              beat  <= 2'd0;
              state <= LEN;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        LEN: begin
          if (req_fire) begin
            if (beat != 2'd0 && sel_req_bits != 32'd0) len_err <= 1'b1;
            if (beat == LEN_LAST) begin
              beat  <= 2'd0;
              state <= is_write ? WDATA : RDATA;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        WDATA: begin
          if (req_fire && remaining == 33'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RDATA: begin
          if (resp_fire && remaining == 33'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end

    // Packet bookkeeping carries no reset: it is always reloaded from the
    // header before it is consulted.
    if (state == CMD && req_fire) is_write <= sel_req_bits[0];
    if (state == LEN && req_fire && beat == 2'd0)
      remaining <= {1'b0, sel_req_bits} + 33'd1;
    else if ((state == WDATA && req_fire) || (state == RDATA && resp_fire))
      remaining <= remaining - 33'd1;
  end

endmodule

// File: tb/tb_tsi_link_arbiter.sv
`timescale 1ns/1ps
module tb_tsi_link_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        c0_req_valid, c0_req_ready, c0_resp_valid, c0_resp_ready;
  logic [31:0] c0_req_bits, c0_resp_bits;
  logic        c1_req_valid, c1_req_ready, c1_resp_valid, c1_resp_ready;
  logic [31:0] c1_req_bits, c1_resp_bits;
  logic        t_req_valid, t_req_ready, t_resp_valid, t_resp_ready;
  logic [31:0] t_req_bits, t_resp_bits;
  logic        busy, owner, len_err;

  tsi_link_arbiter #(.ADDR_WORDS(2), .LEN_WORDS(2)) dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_bits(c0_req_bits),
    .c0_resp_valid(c0_resp_valid), .c0_resp_ready(c0_resp_ready), .c0_resp_bits(c0_resp_bits),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_bits(c1_req_bits),
    .c1_resp_valid(c1_resp_valid), .c1_resp_ready(c1_resp_ready), .c1_resp_bits(c1_resp_bits),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_bits(t_req_bits),
    .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready), .t_resp_bits(t_resp_bits),
    .busy(busy), .owner(owner), .len_err(len_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        own;
    logic [31:0] data;
  } req_t;

  req_t        exp_treq[$];
  logic [31:0] exp_resp0[$];
  logic [31:0] exp_resp1[$];
  logic [31:0] stim0[$];
  logic [31:0] stim1[$];
  logic [31:0] tstim[$];

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  bit count_en = 1'b0;
  bit rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Queue a request word from client c and the matching expectation on the link
  task automatic push_req(input logic c, input logic [31:0] w);
    req_t e;
    e.own  = c;
    e.data = w;
    exp_treq.push_back(e);
    if (c) stim1.push_back(w);
    else   stim0.push_back(w);
  endtask

  task automatic push_resp(input logic c, input logic [31:0] w);
    tstim.push_back(w);
    if (c) exp_resp1.push_back(w);
    else   exp_resp0.push_back(w);
  endtask

  task automatic write1(input logic c, input logic [31:0] addr, input logic [31:0] data);
    push_req(c, 32'h1);
    push_req(c, addr);
    push_req(c, 32'h0);
    push_req(c, 32'h0);
    push_req(c, 32'h0);
    push_req(c, data);
  endtask

  task automatic send_words(input logic c, input int n);
    logic [31:0] w;
    bit fired;
    int guard;
    for (int i = 0; i < n; i++) begin
      w = c ? stim1.pop_front() : stim0.pop_front();
      if (c) begin c1_req_valid = 1'b1; c1_req_bits = w; end
      else   begin c0_req_valid = 1'b1; c0_req_bits = w; end
      fired = 1'b0;
      guard = 0;
      while (!fired) begin
        @(negedge clock);
        fired = c ? c1_req_ready : c0_req_ready;
        @(posedge clock);
        #1;
        guard++;
        if (!fired && guard > 500) begin
          checks++;
          errors++;
          $display("FAIL req_timeout: client %0d word %h not accepted, required accept within 500 cycles", c, w);
          fired = 1'b1;
        end
      end
    end
    if (c) c1_req_valid = 1'b0;
    else   c0_req_valid = 1'b0;
  endtask

  task automatic target_send(input int n, input bit quiet_c0);
    logic [31:0] w;
    bit fired;
    int guard;
    for (int i = 0; i < n; i++) begin
      w = tstim.pop_front();
      t_resp_valid = 1'b1;
      t_resp_bits  = w;
      fired = 1'b0;
      guard = 0;
      while (!fired) begin
        @(negedge clock);
        if (quiet_c0) begin
          check1("rd_c0_resp_quiet", c0_resp_valid, 1'b0);
          check1("rd_treq_blocked", t_req_valid, 1'b0);
          check1("rd_c1_req_ready_blocked", c1_req_ready, 1'b0);
        end
        fired = t_resp_ready;
        @(posedge clock);
        #1;
        guard++;
        if (!fired && guard > 500) begin
          checks++;
          errors++;
          $display("FAIL resp_timeout: word %h not accepted, required accept within 500 cycles", w);
          fired = 1'b1;
        end
      end
    end
    t_resp_valid = 1'b0;
  endtask

  // Scoreboard monitor: compares every word that actually transfers
  initial begin : monitor
    req_t e;
    logic [31:0] r;
    forever begin
      @(negedge clock);
      if (t_req_valid && t_req_ready) begin
        checks++;
        if (exp_treq.size() == 0) begin
          errors++;
          $display("FAIL treq_unexpected: got %h owner %0d expected no word", t_req_bits, owner);
        end else begin
          e = exp_treq.pop_front();
          if (t_req_bits !== e.data || owner !== e.own) begin
            errors++;
            $display("FAIL treq_word: got %h owner %0d expected %h owner %0d", t_req_bits, owner, e.data, e.own);
          end
        end
      end
      if (c0_resp_valid && c0_resp_ready) begin
        checks++;
        if (exp_resp0.size() == 0) begin
          errors++;
          $display("FAIL c0_resp_unexpected: got %h expected no word", c0_resp_bits);
        end else begin
          r = exp_resp0.pop_front();
          if (c0_resp_bits !== r) begin
            errors++;
            $display("FAIL c0_resp_word: got %h expected %h", c0_resp_bits, r);
          end
        end
      end
      if (c1_resp_valid && c1_resp_ready) begin
        checks++;
        if (exp_resp1.size() == 0) begin
          errors++;
          $display("FAIL c1_resp_unexpected: got %h expected no word", c1_resp_bits);
        end else begin
          r = exp_resp1.pop_front();
          if (c1_resp_bits !== r) begin
            errors++;
            $display("FAIL c1_resp_word: got %h expected %h", c1_resp_bits, r);
          end
        end
      end
    end
  end

  initial begin : busy_counter
    forever begin
      @(negedge clock);
      if (count_en && busy) busy_cnt++;
    end
  end

  initial begin : backpressure
    forever begin
      @(posedge clock);
      #1;
      if (rand_en) begin
        t_req_ready   = 1'($urandom_range(0, 1));
        c0_resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    c0_req_bits = 32'd0; c1_req_bits = 32'd0; t_resp_bits = 32'd0;
    // Active inputs during reset must not leak through
    c0_req_valid = 1'b1; c1_req_valid = 1'b1; t_resp_valid = 1'b1;
    t_req_ready = 1'b1; c0_resp_ready = 1'b1; c1_resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check1("reset_busy", busy, 1'b0);
    check1("reset_owner", owner, 1'b0);
    check1("reset_len_err", len_err, 1'b0);
    check1("reset_t_req_valid", t_req_valid, 1'b0);
    check1("reset_c0_req_ready", c0_req_ready, 1'b0);
    check1("reset_c1_req_ready", c1_req_ready, 1'b0);
    check1("reset_t_resp_ready", t_resp_ready, 1'b0);
    check1("reset_c0_resp_valid", c0_resp_valid, 1'b0);
    check1("reset_c1_resp_valid", c1_resp_valid, 1'b0);
    check("reset_t_req_bits", t_req_bits, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    c0_req_valid = 1'b0; c1_req_valid = 1'b0; t_resp_valid = 1'b0;

    // Client 0 write, L = 3: 9 words, one idle grant cycle, busy for 9 cycles
    push_req(0, 32'h1);
    push_req(0, 32'h1000);
    push_req(0, 32'h0);
    push_req(0, 32'h3);
    push_req(0, 32'h0);
    for (int i = 0; i < 4; i++) push_req(0, 32'hD000_0000 + 32'(i));
    busy_cnt = 0;
    count_en = 1'b1;
    c0_req_valid = 1'b1;
    c0_req_bits  = 32'h1;
    @(negedge clock);
    check1("t1_idle_gap_t_req_valid", t_req_valid, 1'b0);
    check1("t1_idle_gap_busy", busy, 1'b0);
    send_words(0, 9);
    repeat (3) @(posedge clock);
    #1;
    count_en = 1'b0;
    check("t1_busy_cycles", busy_cnt, 32'd9);
    check1("t1_idle_after", busy, 1'b0);
    check("t1_treq_drained", exp_treq.size(), 32'd0);

    // Client 1 read, L = 1; a stray target word is held off until RDATA
    t_resp_valid = 1'b1;
    t_resp_bits  = 32'hBAD0_0000;
    push_req(1, 32'h0);
    push_req(1, 32'h2000);
    push_req(1, 32'h0);
    push_req(1, 32'h1);
    push_req(1, 32'h0);
    send_words(1, 5);
    push_resp(1, 32'hA5A5_0000);
    push_resp(1, 32'hA5A5_0001);
    c1_req_valid = 1'b1;
    c1_req_bits  = 32'hDEAD_BEEF;
    target_send(2, 1'b1);
    c1_req_valid = 1'b0;
    @(negedge clock);
    check1("t2_idle_after", busy, 1'b0);
    check("t2_resp1_drained", exp_resp1.size(), 32'd0);

    // Both clients stream 1-word writes: grants alternate 0,1,0,1
    write1(0, 32'hA100, 32'hA1A1_A1A1);
    write1(1, 32'hB100, 32'hB1B1_B1B1);
    write1(0, 32'hA200, 32'hA2A2_A2A2);
    write1(1, 32'hB200, 32'hB2B2_B2B2);
    fork
      send_words(0, 12);
      send_words(1, 12);
    join
    @(negedge clock);
    check("t3_treq_drained", exp_treq.size(), 32'd0);

    // Client 0 read, L = 7, random backpressure on both sides
    push_req(0, 32'h0000_0010);
    push_req(0, 32'h3000);
    push_req(0, 32'h0);
    push_req(0, 32'h7);
    push_req(0, 32'h0);
    rand_en = 1'b1;
    send_words(0, 5);
    for (int i = 0; i < 8; i++) push_resp(0, 32'hC000_0000 + 32'(i));
    target_send(8, 1'b0);
    rand_en = 1'b0;
    @(posedge clock);
    #2;
    t_req_ready   = 1'b1;
    c0_resp_ready = 1'b1;
    @(negedge clock);
    check1("t4_idle_after", busy, 1'b0);
    check("t4_resp0_drained", exp_resp0.size(), 32'd0);

    // Nonzero second length word: sticky len_err, packet still has 1 data word
    check1("t5_len_err_before", len_err, 1'b0);
    push_req(0, 32'h1);
    push_req(0, 32'h4000);
    push_req(0, 32'h0);
    push_req(0, 32'h0);
    push_req(0, 32'h5);
    push_req(0, 32'h0000_00D5);
    send_words(0, 6);
    @(negedge clock);
    check1("t5_len_err_set", len_err, 1'b1);
    check1("t5_idle_after", busy, 1'b0);
    repeat (5) @(negedge clock);
    check1("t5_len_err_sticky", len_err, 1'b1);

    // Reset in the middle of a client 1 write data phase
    push_req(1, 32'h1);
    push_req(1, 32'h5000);
    push_req(1, 32'h0);
    push_req(1, 32'h3);
    push_req(1, 32'h0);
    push_req(1, 32'hE000_0000);
    send_words(1, 6);
    @(negedge clock);
    check1("t6_busy_mid", busy, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    c1_req_valid = 1'b1;
    c1_req_bits  = 32'hE000_0001;
    t_resp_valid = 1'b1;
    @(negedge clock);
    check1("t6_busy", busy, 1'b0);
    check1("t6_owner", owner, 1'b0);
    check1("t6_len_err", len_err, 1'b0);
    check1("t6_t_req_valid", t_req_valid, 1'b0);
    check1("t6_c1_req_ready", c1_req_ready, 1'b0);
    check1("t6_t_resp_ready", t_resp_ready, 1'b0);
    check1("t6_c1_resp_valid", c1_resp_valid, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    c1_req_valid = 1'b0;
    t_resp_valid = 1'b0;
    write1(0, 32'h6000, 32'hF0F0_F0F0);
    send_words(0, 6);
    @(negedge clock);
    check1("t6_idle_after", busy, 1'b0);

    repeat (2) @(negedge clock);
    check("final_treq_drained", exp_treq.size(), 32'd0);
    check("final_resp0_drained", exp_resp0.size(), 32'd0);
    check("final_resp1_drained", exp_resp1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
